mips_cpu_muldiv: RTL and testbench

Multi-cycle multiply/divide sequencer owning the HI/LO register pair of the MIPS CPU. It takes the slow MULT/MULTU/DIV/DIVU operations and MTHI/MTLO writes out of the single-cycle ALU. It iterates one bit per cycle and presents HI/LO to the datapath for MFHI/MFLO. The control unit stalls on `busy`.

---
 rtl/mips_cpu_muldiv_pkg.sv | 32 +++
 rtl/mips_cpu_muldiv_step.sv | 39 +++
 rtl/mips_cpu_muldiv.sv | 154 +++++++++++++++
 tb/tb_mips_cpu_muldiv.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/mips_cpu_muldiv_pkg.sv
// mips_cpu_muldiv_pkg
// Shared types and constants for the HI/LO multiply/divide sequencer:
//   muldiv_op_t    - command encoding driven by the control unit
//   muldiv_state_t - sequencer FSM states
//   MULDIV_ITER    - one iteration per operand bit
//   abs32          - two's-complement magnitude helper
package mips_cpu_muldiv_pkg;

    localparam int MULDIV_ITER = 32;

    typedef enum logic [2:0] {
        NONE  = 3'd0,
        MULT  = 3'd1,
        MULTU = 3'd2,
        DIV   = 3'd3,
        DIVU  = 3'd4,
        MTHI  = 3'd5,
        MTLO  = 3'd6
    } muldiv_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } muldiv_state_t;

    // 0x8000_0000 maps onto itself, which is the correct unsigned magnitude.
    function automatic logic [31:0] abs32(input logic [31:0] v);
        return v[31] ? (32'd0 - v) : v;
    endfunction

endpackage

// File: rtl/mips_cpu_muldiv_step.sv
// mips_cpu_muldiv_step
// One combinational iteration of the shift-add multiplier or the restoring
// divider, sharing a single adder/subtractor.
//   div_mode in  1  : 0 = multiply step, 1 = divide step
//   acc      in  64 : {product hi, multiplier/product lo} or {remainder, quotient}
//   opnd     in  32 : multiplicand magnitude (multiply) or divisor magnitude (divide)
//   nxt      out 64 : accumulator after this iteration
module mips_cpu_muldiv_step (
    input  logic        div_mode,
    input  logic [63:0] acc,
    input  logic [31:0] opnd,
    output logic [63:0] nxt
);

    logic [33:0] lhs;
    logic [33:0] sum;

    always_comb begin
        // Divide works on the left-shifted remainder (33 significant bits);
        // multiply adds into the unshifted upper half.
        lhs = div_mode ? {1'b0, acc[63:31]} : {2'b00, acc[63:32]};
        sum = div_mode ? (lhs - {2'b00, opnd}) : (lhs + {2'b00, opnd});
        nxt = acc;
        if (div_mode) begin
            // sum[33] is the borrow: set means the trial subtract failed
            if (sum[33])
                nxt = {acc[62:0], 1'b0};
            else
                nxt = {sum[31:0], acc[30:0], 1'b1};
        end else begin
            // Carry of the add lands in bit 63 after the right shift
            if (acc[0])
                nxt = {sum[32:0], acc[31:1]};
            else
                nxt = {1'b0, acc[63:1]};
        end
    end

endmodule

// File: rtl/mips_cpu_muldiv.sv
// mips_cpu_muldiv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer owning HI/LO; also services
// MTHI/MTLO. One bit per cycle, 32 RUN cycles plus one FIX cycle.
//   clk, rst_n    : clock, asynchronous active-low reset
//   start, op     : command valid / command, sampled only while idle
//   a, b          : rs / rt operands
//   flush         : cancel the in-flight operation (RUN or FIX)
//   busy          : operation in flight
//   done          : one-cycle pulse after HI/LO were written
//   hi, lo        : HI/LO registers
module mips_cpu_muldiv
    import mips_cpu_muldiv_pkg::*;
#(
    parameter int ITER = MULDIV_ITER
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  muldiv_op_t  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int CNT_W = $clog2(ITER);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

    muldiv_state_t    state;
    logic [CNT_W-1:0] cnt;
    logic [63:0]      acc;
    logic [63:0]      acc_nxt;
    logic [31:0]      opnd;
    logic [31:0]      a_raw;
    logic             is_div;
    logic             is_sgn;
    logic             neg_q;
    logic             neg_r;
    logic             div0;

    // Command decode
    logic        cmd_go;
    logic        cmd_div;
    logic        cmd_sgn;
    logic [31:0] mag_a;
    logic [31:0] mag_b;

    always_comb begin
        cmd_go  = 1'b0;
        cmd_div = 1'b0;
        cmd_sgn = 1'b0;
        case (op)
            MULT:    begin cmd_go = 1'b1; cmd_sgn = 1'b1; end
            MULTU:   begin cmd_go = 1'b1; end
            DIV:     begin cmd_go = 1'b1; cmd_div = 1'b1; cmd_sgn = 1'b1; end
            DIVU:    begin cmd_go = 1'b1; cmd_div = 1'b1; end
            default: ;
        endcase
        mag_a = cmd_sgn ? abs32(a) : a;
        mag_b = cmd_sgn ? abs32(b) : b;
    end

    mips_cpu_muldiv_step u_step (
        .div_mode (is_div),
        .acc      (acc),
        .opnd     (opnd),
        .nxt      (acc_nxt)
    );

    // Sign fix-up and divide-by-zero override applied in FIX
    logic [63:0] prod_fix;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;

    assign prod_fix = (is_sgn && neg_q) ? (64'd0 - acc) : acc;
    assign quo_fix  = div0 ? 32'hFFFF_FFFF :
                      (is_sgn && neg_q) ? (32'd0 - acc[31:0]) : acc[31:0];
    assign rem_fix  = div0 ? a_raw :
                      (is_sgn && neg_r) ? (32'd0 - acc[63:32]) : acc[63:32];

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            acc    <= '0;
            opnd   <= '0;
            a_raw  <= '0;
            is_div <= 1'b0;
            is_sgn <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            div0   <= 1'b0;
            done   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (cmd_go) begin
                            state  <= RUN;
                            cnt    <= '0;
                            is_div <= cmd_div;
                            is_sgn <= cmd_sgn;
                            neg_q  <= a[31] ^ b[31];
                            neg_r  <= a[31];
                            div0   <= cmd_div && (b == 32'd0);
                            a_raw  <= a;
                            // Multiplier sits in the low half and shifts out;
                            // dividend sits in the low half and shifts up.
                            acc    <= {32'd0, cmd_div ? mag_a : mag_b};
                            opnd   <= cmd_div ? mag_b : mag_a;
                        end else if (op == MTHI) begin
                            hi <= a;
                        end else if (op == MTLO) begin
                            lo <= a;
                        end
                    end
                end
                RUN: begin
                    if (flush) begin
                        state <= IDLE;
                    end else begin
                        acc <= acc_nxt;
                        cnt <= cnt + 1'b1;
                        if (cnt == CNT_LAST)
                            state <= FIX;
                    end
                end
                FIX: begin
                    state <= IDLE;
                    if (!flush) begin
                        done <= 1'b1;
                        if (is_div) begin
                            hi <= rem_fix;
                            lo <= quo_fix;
                        end else begin
                            hi <= prod_fix[63:32];
                            lo <= prod_fix[31:0];
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_cpu_muldiv.sv
// tb_mips_cpu_muldiv
// Directed vectors for the multiply/divide sequencer. Stimulus pushes the
// expected HI/LO and completion cycle into a scoreboard; a monitor pops and
// compares whenever done pulses.
module tb_mips_cpu_muldiv;
    import mips_cpu_muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    muldiv_op_t  op = NONE;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        flush = 1'b0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    mips_cpu_muldiv dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .flush (flush),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          at;
    } exp_t;

    exp_t sb[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest expectation
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d expected no done", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("hi", hi, e.hi);
                chk("lo", lo, e.lo);
                chk("done_cycle", cyc, e.at);
            end
        end
    end

    // Called at a negedge; start is sampled at the next posedge.
    task automatic issue(input muldiv_op_t o, input logic [31:0] xa, input logic [31:0] xb,
                         input bit push, input logic [31:0] eh, input logic [31:0] el);
        start = 1'b1;
        op    = o;
        a     = xa;
        b     = xb;
        // done observed 34 edges after drive time: accept edge + 33
        if (push) sb.push_back('{hi: eh, lo: el, at: cyc + 34});
        @(negedge clk);
        start = 1'b0;
        op    = NONE;
        chk("busy_after_start", {31'd0, busy}, 32'd1);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!done) begin
            n_vec++;
            n_fail++;
            $display("FAIL done_timeout: got no done after %0d cycles expected done", n);
        end else begin
            chk("busy_with_done", {31'd0, busy}, 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);

        // Back-to-back: each issue is driven in the done cycle of the previous
        issue(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFE, 32'h0000_0001);
        wait_done();
        issue(MULT,  32'hFFFF_FFFD, 32'd5,         1, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        wait_done();
        issue(DIV,   32'hFFFF_FFF9, 32'd2,         1, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        wait_done();
        issue(DIVU,  32'd7,         32'd2,         1, 32'd1,         32'd3);
        wait_done();
        issue(DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1, 32'd0,         32'h8000_0000);
        wait_done();
        issue(DIVU,  32'h0000_1234, 32'd0,         1, 32'h0000_1234, 32'hFFFF_FFFF);
        wait_done();

        // MTHI: visible next cycle, no done
        @(negedge clk);
        start = 1'b1; op = MTHI; a = 32'hAAAA_5555;
        @(negedge clk);
        start = 1'b0; op = NONE;
        chk("mthi_hi", hi, 32'hAAAA_5555);
        chk("mthi_lo_kept", lo, 32'hFFFF_FFFF);
        chk("mthi_no_done", {31'd0, done}, 32'd0);

        // start/MTLO while busy are ignored
        issue(MULTU, 32'd3, 32'd4, 1, 32'd0, 32'd12);
        repeat (3) @(negedge clk);
        start = 1'b1; op = MULT; a = 32'd7; b = 32'd7;
        @(negedge clk);
        op = MTLO; a = 32'hDEAD_BEEF;
        @(negedge clk);
        start = 1'b0; op = NONE;
        @(negedge clk);
        chk("busy_mtlo_lo", lo, 32'hFFFF_FFFF);
        chk("busy_mtlo_hi", hi, 32'hAAAA_5555);
        wait_done();

        // flush at RUN cycle 10
        @(negedge clk);
        issue(MULTU, 32'd5, 32'd5, 0, 32'd0, 32'd0);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_busy", {31'd0, busy}, 32'd0);
        chk("flush_done", {31'd0, done}, 32'd0);
        chk("flush_hi", hi, 32'd0);
        chk("flush_lo", lo, 32'd12);
        repeat (40) @(negedge clk);

        // flush in IDLE with coincident start: start still accepted
        flush = 1'b1;
        issue(DIVU, 32'd100, 32'd7, 1, 32'd2, 32'd14);
        flush = 1'b0;
        wait_done();

        // asynchronous reset mid-RUN
        @(negedge clk);
        issue(MULTU, 32'hFFFF_FFFF, 32'd2, 0, 32'd0, 32'd0);
        repeat (5) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_done", {31'd0, done}, 32'd0);
        chk("arst_hi", hi, 32'd0);
        chk("arst_lo", lo, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        issue(DIVU, 32'd9, 32'd3, 1, 32'd0, 32'd3);
        wait_done();

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
